// File: rtl/pipe_pkg.sv
// Shared types and constants for the valid/ready pipeline stage.
package pipe_pkg;

    typedef enum logic [1:0] {
        PIPE_MODE_FWD  = 2'd0,
        PIPE_MODE_SKID = 2'd1
    } pipe_mode_e;

    localparam int OCC_W = 2;

endpackage : pipe_pkg

// File: rtl/pipe_slot.sv
// One holding slot: a valid flag plus payload register.
// Priority is kill > load > clr.
module pipe_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              kill,
    input  logic              load,
    input  logic              clr,
    input  logic [DATA_W-1:0] d,
    output logic              vld,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= 1'b0;
            q   <= '0;
        end else if (kill) begin
            vld <= 1'b0;
        end else if (load) begin
            vld <= 1'b1;
            q   <= d;
        end else if (clr) begin
            vld <= 1'b0;
        end
    end

endmodule : pipe_slot

// File: rtl/pipe_stage.sv
// Valid/ready pipeline stage: a plain forwarding register, or a two-entry
// skid buffer whose pin_ready is isolated from pout_ready.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int         DATA_W = 32,
    parameter pipe_mode_e MODE   = PIPE_MODE_FWD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              pin_valid,
    input  logic [DATA_W-1:0] pin_data,
    output logic              pin_ready,
    output logic              pout_valid,
    output logic [DATA_W-1:0] pout_data,
    input  logic              pout_ready,
    output logic [OCC_W-1:0]  occupancy
);

    logic             xfer_in;
    logic             xfer_out;
    logic [OCC_W-1:0] occ_p0;

    generate
        if (MODE == PIPE_MODE_FWD) begin : g_fwd
            logic              main_vld_p0;
            logic [DATA_W-1:0] main_q_p0;

            assign pin_ready = (~main_vld_p0 | pout_ready) & ~flush;

            pipe_slot #(.DATA_W(DATA_W)) u_main (
                .clk  (clk),
                .rst  (rst),
                .kill (flush),
                .load (pin_ready & pin_valid),
                .clr  (pin_ready & ~pin_valid),
                .d    (pin_data),
                .vld  (main_vld_p0),
                .q    (main_q_p0)
            );

            assign pout_valid = main_vld_p0;
            assign pout_data  = main_q_p0;
        end else if (MODE == PIPE_MODE_SKID) begin : g_skid
            logic              main_vld_p0;
            logic              skid_vld_p0;
            logic [DATA_W-1:0] main_q_p0;
            logic [DATA_W-1:0] skid_q_p0;
            logic              acc_in;
            logic              main_load;
            logic              main_clr;
            logic              skid_load;
            logic              skid_clr;
            logic [DATA_W-1:0] main_d;

            // Ready comes only from state (and reset), never from pout_ready.
            assign pin_ready = ~skid_vld_p0 & ~flush & rst;
            assign acc_in    = pin_valid & pin_ready;

            assign main_load = skid_vld_p0 ? pout_ready
                                           : acc_in & (~main_vld_p0 | pout_ready);
            assign main_d    = skid_vld_p0 ? skid_q_p0 : pin_data;
            assign main_clr  = main_vld_p0 & pout_ready;
            assign skid_load = acc_in & main_vld_p0 & ~pout_ready;
            assign skid_clr  = skid_vld_p0 & pout_ready;

            pipe_slot #(.DATA_W(DATA_W)) u_main (
                .clk  (clk),
                .rst  (rst),
                .kill (flush),
                .load (main_load),
                .clr  (main_clr),
                .d    (main_d),
                .vld  (main_vld_p0),
                .q    (main_q_p0)
            );

            pipe_slot #(.DATA_W(DATA_W)) u_skid (
                .clk  (clk),
                .rst  (rst),
                .kill (flush),
                .load (skid_load),
                .clr  (skid_clr),
                .d    (pin_data),
                .vld  (skid_vld_p0),
                .q    (skid_q_p0)
            );

            assign pout_valid = main_vld_p0;
            assign pout_data  = main_q_p0;
        end else begin : g_bad
            $error("pipe_stage: unsupported MODE value");
            assign pin_ready  = 1'b0;
            assign pout_valid = 1'b0;
            assign pout_data  = '0;
        end
    endgenerate

    assign xfer_in  = pin_valid & pin_ready;
    assign xfer_out = pout_valid & pout_ready;

    // Occupancy tracks held beats as a running count rather than decoding valids.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_p0 <= '0;
        end else if (flush) begin
            occ_p0 <= '0;
        end else begin
            occ_p0 <= occ_p0 + OCC_W'(xfer_in) - OCC_W'(xfer_out);
        end
    end

    assign occupancy = occ_p0;

endmodule : pipe_stage

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter DATA_W, default 32, payload width in bits (>=1).
REQ-002 Parameter MODE, default PIPE_MODE_FWD, selects stage type: PIPE_MODE_FWD (single register) or PIPE_MODE_SKID (two-entry skid buffer).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous kill of all held beats.
REQ-006 pin_valid  input  1  upstream beat present.
REQ-007 pin_data  input  DATA_W  upstream payload.
REQ-008 pin_ready  output  1  stage accepts a beat this cycle.
REQ-009 pout_valid  output  1  stage presents a beat.
REQ-010 pout_data  output  DATA_W  presented payload.
REQ-011 pout_ready  input  1  downstream accepts this cycle.
REQ-012 occupancy  output  2  number of beats held (0..1 FWD, 0..2 SKID).

Function
REQ-013 Transfer in = pin_valid & pin_ready; transfer out = pout_valid & pout_ready, both at the rising edge.
REQ-014 Latency from transfer in to pout_valid is exactly 1 cycle in both modes; beats leave in arrival order, none dropped or duplicated except by flush.
REQ-015 pout_valid and pout_data are driven only from registers; pout_data is stable while pout_valid & ~pout_ready.
REQ-016 FWD: pin_ready = (~valid_q | pout_ready) & ~flush (combinational from pout_ready); on pin_ready, valid_q <= pin_valid, data_q <= pin_data only when pin_valid.
REQ-017 FWD sustains one beat per cycle with pout_ready held high.
REQ-018 SKID: pin_ready = ~skid_valid & ~flush, and does not combinationally depend on pout_ready or pin_valid.
REQ-019 SKID, main empty or draining: the accepted beat loads main.
REQ-020 SKID, main full and not draining: the accepted beat loads skid.
REQ-021 SKID, skid full and pout_ready: main <= skid, skid_valid clears; no input is accepted that cycle.
REQ-022 SKID sustains one beat per cycle with pout_ready held high; a single-cycle pout_ready drop loses no throughput beyond that cycle.
REQ-023 Flush: all valids clear at the next edge, with priority over any load; pin_ready = 0 during flush; a transfer out completing in the flush cycle is legal and counts.
REQ-024 occupancy equals the count of set valid bits, registered.
REQ-025 Unsupported MODE value: elaboration-time error.

Reset
REQ-026 rst low: valid_q, skid_valid, data registers and occupancy clear to 0 asynchronously, so pout_valid = 0 and pout_data = 0.
REQ-027 During reset: pin_ready = 0 in SKID mode; in FWD mode it follows REQ-016 with valid_q = 0.
REQ-028 Reset release mid-traffic: the first accept is possible on the first edge after release; no beat held before reset reappears.

Structure
REQ-029 Package pipe_pkg holds the MODE enum (PIPE_MODE_FWD, PIPE_MODE_SKID) and the occupancy width constant.
REQ-030 Single sub-module pipe_slot (valid plus DATA_W payload register with load/clear) is instantiated once for FWD and twice for SKID.

Verification
REQ-031 FWD, pout_ready = 1, pin_valid = 1, data 1,2,3,4 on consecutive cycles -> pout_data 1,2,3,4 one cycle later; pin_ready constantly 1.
REQ-032 SKID, send A,B,C; drop pout_ready the cycle A is presented -> B goes to skid, pin_ready = 0 next cycle, occupancy = 2; on pout_ready = 1 outputs are A,B,C in order.
REQ-033 Either mode, occupancy 2 (SKID) or 1 (FWD) with flush = 1 and pin_valid = 1 -> next cycle pout_valid = 0, occupancy = 0, the flush-cycle input is not accepted.
REQ-034 Stall hold: pout_valid = 1, pout_ready = 0 for 5 cycles with pin_data toggling -> pout_data is unchanged across all 5 cycles.
REQ-035 Assert rst low asynchronously mid-burst (between edges) -> pout_valid = 0 immediately; after release, send 0xDEAD -> it is the first beat out.
REQ-036 Random valid/ready (50%) for 10k beats per mode against a scoreboard -> in-order delivery with zero loss, and pin_ready never depends on pout_ready in SKID mode.
